// File: rtl/lc2k_pkg.sv
// LC2K shared definitions: widths, instruction field positions, opcodes and the ID/EX bundle.
// Also holds the per-opcode source/destination usage rules that decode relies on.
package lc2k_pkg;
  localparam int XLEN   = 32;
  localparam int NREGS  = 8;
  localparam int REG_W  = $clog2(NREGS);

  localparam int OP_HI  = 24;
  localparam int RA_HI  = 21;
  localparam int RB_HI  = 18;
  localparam int DST_HI = 2;
  localparam int OFF_HI = 15;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_NOR  = 3'b001,
    OP_LW   = 3'b010,
    OP_SW   = 3'b011,
    OP_BEQ  = 3'b100,
    OP_JALR = 3'b101,
    OP_HALT = 3'b110,
    OP_NOOP = 3'b111
  } opcode_e;

  typedef struct packed {
    opcode_e          op;
    logic [XLEN-1:0]  data_a;
    logic [XLEN-1:0]  data_b;
    logic [XLEN-1:0]  offset;
    logic [REG_W-1:0] dest;
    logic             wen;
    logic [XLEN-1:0]  pc;
  } idex_t;

  function automatic logic uses_a(input opcode_e op);
    return !(op inside {OP_HALT, OP_NOOP});
  endfunction

  function automatic logic uses_b(input opcode_e op);
    return op inside {OP_ADD, OP_NOR, OP_SW, OP_BEQ};
  endfunction

  function automatic logic writes_reg(input opcode_e op);
    return op inside {OP_ADD, OP_NOR, OP_LW, OP_JALR};
  endfunction
endpackage

// File: rtl/lc2k_decode_if.sv
// Decode stage bus: fetch handshake, register-file read port, ID/EX handshake,
// write-back retire and branch flush. slave = decode stage, master = surrounding pipeline.
interface lc2k_decode_if;
  import lc2k_pkg::*;

  logic             if_valid;
  logic             if_ready;
  logic [XLEN-1:0]  if_instr;
  logic [XLEN-1:0]  if_pc;
  logic [REG_W-1:0] rf_regA;
  logic [REG_W-1:0] rf_regB;
  logic [XLEN-1:0]  rf_dataA;
  logic [XLEN-1:0]  rf_dataB;
  logic             ex_valid;
  logic             ex_ready;
  logic [2:0]       ex_opcode;
  logic [XLEN-1:0]  ex_dataA;
  logic [XLEN-1:0]  ex_dataB;
  logic [XLEN-1:0]  ex_offset;
  logic [REG_W-1:0] ex_dest;
  logic             ex_wen;
  logic [XLEN-1:0]  ex_pc;
  logic             wb_valid;
  logic [REG_W-1:0] wb_reg;
  logic             flush;
  logic             halted;

  modport slave (
    input  if_valid, if_instr, if_pc, rf_dataA, rf_dataB, ex_ready, wb_valid, wb_reg, flush,
    output if_ready, rf_regA, rf_regB, ex_valid, ex_opcode, ex_dataA, ex_dataB, ex_offset,
           ex_dest, ex_wen, ex_pc, halted
  );

  modport master (
    output if_valid, if_instr, if_pc, rf_dataA, rf_dataB, ex_ready, wb_valid, wb_reg, flush,
    input  if_ready, rf_regA, rf_regB, ex_valid, ex_opcode, ex_dataA, ex_dataB, ex_offset,
           ex_dest, ex_wen, ex_pc, halted
  );
endinterface

// File: rtl/lc2k_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register.
// Both clears apply before the set, so a clear and set of the same register leaves it pending.
module lc2k_scoreboard #(
  parameter int NREGS = 8,
  parameter int REG_W = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr0_en,
  input  logic [REG_W-1:0] i_clr0_idx,
  input  logic             i_clr1_en,
  input  logic [REG_W-1:0] i_clr1_idx,
  input  logic             i_set_en,
  input  logic [REG_W-1:0] i_set_idx,
  output logic [NREGS-1:0] o_sb
);
  logic [NREGS-1:0] r_sb;
  logic [NREGS-1:0] w_sb_nxt;

  always_comb begin
    w_sb_nxt = r_sb;
    if (i_clr0_en) w_sb_nxt[i_clr0_idx] = 1'b0;
    if (i_clr1_en) w_sb_nxt[i_clr1_idx] = 1'b0;
    if (i_set_en)  w_sb_nxt[i_set_idx]  = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sb <= '0;
    else        r_sb <= w_sb_nxt;
  end

  assign o_sb = r_sb;
endmodule

// File: rtl/lc2k_decode.sv
// LC2K decode/issue stage: field split, RF read addressing, RAW/WAW interlock against the
// pending-write scoreboard, and a single ID/EX register handed to execute over valid/ready.
module lc2k_decode
  import lc2k_pkg::*;
(
  input logic          clk,
  input logic          rst_n,
  lc2k_decode_if.slave bus
);
  opcode_e          w_op;
  logic [REG_W-1:0] w_ra, w_rb, w_dest;
  logic             w_use_a, w_use_b, w_wen;
  logic [XLEN-1:0]  w_offset;
  logic [NREGS-1:0] w_sb;
  logic             w_hazard, w_out_free, w_if_ready, w_issue, w_kill, w_accept;
  logic             w_unused;

  idex_t            r_ex;
  logic             r_ex_valid;
  logic             r_halt_pend;
  logic             r_halted;

  assign w_op     = opcode_e'(bus.if_instr[OP_HI -: 3]);
  assign w_ra     = bus.if_instr[RA_HI -: REG_W];
  assign w_rb     = bus.if_instr[RB_HI -: REG_W];
  assign w_use_a  = uses_a(w_op);
  assign w_use_b  = uses_b(w_op);
  assign w_wen    = writes_reg(w_op);
  assign w_offset = {{(XLEN-OFF_HI-1){bus.if_instr[OFF_HI]}}, bus.if_instr[OFF_HI:0]};
  assign w_unused = ^bus.if_instr[XLEN-1:OP_HI+1];

  always_comb begin
    w_dest = '0;
    unique case (w_op)
      OP_ADD, OP_NOR: w_dest = bus.if_instr[DST_HI -: REG_W];
      OP_LW, OP_JALR: w_dest = w_rb;
      default:        w_dest = '0;
    endcase
  end

  // Scoreboard is read as registered: a retiring write-back only unblocks next cycle.
  assign w_hazard   = (w_use_a & w_sb[w_ra]) | (w_use_b & w_sb[w_rb]) | (w_wen & w_sb[w_dest]);
  assign w_out_free = ~r_ex_valid | bus.ex_ready;
  assign w_if_ready = w_out_free & ~w_hazard & ~bus.flush & ~r_halt_pend & ~r_halted;
  assign w_issue    = bus.if_valid & w_if_ready;
  // A flushed bundle is never treated as accepted, even if execute raised ready.
  assign w_kill     = r_ex_valid & bus.flush;
  assign w_accept   = r_ex_valid & bus.ex_ready & ~bus.flush;

  lc2k_scoreboard #(.NREGS(NREGS), .REG_W(REG_W)) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr0_en  (bus.wb_valid),
    .i_clr0_idx (bus.wb_reg),
    .i_clr1_en  (w_kill & r_ex.wen),
    .i_clr1_idx (r_ex.dest),
    .i_set_en   (w_issue & w_wen),
    .i_set_idx  (w_dest),
    .o_sb       (w_sb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex        <= '0;
      r_ex_valid  <= 1'b0;
      r_halt_pend <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      if (bus.flush) begin
        r_ex_valid <= 1'b0;
      end else if (w_issue) begin
        r_ex_valid  <= 1'b1;
        r_ex.op     <= w_op;
        r_ex.data_a <= bus.rf_dataA;
        r_ex.data_b <= bus.rf_dataB;
        r_ex.offset <= w_offset;
        r_ex.dest   <= w_dest;
        r_ex.wen    <= w_wen;
        r_ex.pc     <= bus.if_pc;
      end else if (w_accept) begin
        r_ex_valid <= 1'b0;
      end

      if (w_issue && w_op == OP_HALT)                   r_halt_pend <= 1'b1;
      else if ((w_kill || w_accept) && r_ex.op == OP_HALT) r_halt_pend <= 1'b0;

      if (w_accept && r_ex.op == OP_HALT) r_halted <= 1'b1;
    end
  end

  assign bus.if_ready  = w_if_ready;
  assign bus.rf_regA   = w_ra;
  assign bus.rf_regB   = w_rb;
  assign bus.ex_valid  = r_ex_valid;
  assign bus.ex_opcode = r_ex.op;
  assign bus.ex_dataA  = r_ex.data_a;
  assign bus.ex_dataB  = r_ex.data_b;
  assign bus.ex_offset = r_ex.offset;
  assign bus.ex_dest   = r_ex.dest;
  assign bus.ex_wen    = r_ex.wen;
  assign bus.ex_pc     = r_ex.pc;
  assign bus.halted    = r_halted;
endmodule

// File: tb/tb_lc2k_decode.sv
// Bench for lc2k_decode: per-opcode decode table, directed interlock/flush/halt sequences,
// and a randomized stream checked against a behavioural pipeline model.
module tb_lc2k_decode;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  lc2k_decode_if bus();
  lc2k_decode dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [31:0] rfval(input logic [2:0] i);
    return 32'hA5A5_0000 ^ (32'(i) * 32'h1111_1111);
  endfunction

  always_comb begin
    bus.rf_dataA = rfval(bus.rf_regA);
    bus.rf_dataB = rfval(bus.rf_regB);
  end

  typedef struct packed {
    logic [2:0] op; logic ua; logic ub; logic wen; logic [2:0] dest; logic [31:0] off;
  } dec_t;

  typedef struct packed {
    logic [2:0] op; logic [31:0] da; logic [31:0] db; logic [31:0] off;
    logic [2:0] dest; logic wen; logic [31:0] pc;
  } mb_t;

  typedef struct {
    logic [31:0] instr; logic [2:0] op; logic [2:0] dest; logic wen; logic [31:0] off;
  } vec_t;

  function automatic dec_t dec(input logic [31:0] ins);
    dec_t d;
    d.op   = ins[24:22];
    d.ua   = d.op < 3'd6;
    d.ub   = (d.op == 3'd0) || (d.op == 3'd1) || (d.op == 3'd3) || (d.op == 3'd4);
    d.wen  = (d.op <= 3'd2) || (d.op == 3'd5);
    d.dest = !d.wen ? 3'd0 : ((d.op <= 3'd1) ? ins[2:0] : ins[18:16]);
    d.off  = 32'($signed(ins[15:0]));
    return d;
  endfunction

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                     input logic rdy, input logic wv, input logic [2:0] wr, input logic fl);
    @(negedge clk);
    bus.if_valid = v; bus.if_instr = ins; bus.if_pc = pc;
    bus.ex_ready = rdy; bus.wb_valid = wv; bus.wb_reg = wr; bus.flush = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.if_valid = 0; bus.if_instr = 0; bus.if_pc = 0; bus.ex_ready = 0;
    bus.wb_valid = 0; bus.wb_reg = 0; bus.flush = 0;
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  // behavioural model state
  bit [7:0] m_pend;
  bit       m_exv, m_hp, m_hlt;
  mb_t      m_b;
  int       xq[$];

  task automatic model_reset();
    m_pend = '0; m_exv = 0; m_hp = 0; m_hlt = 0; m_b = '0; xq.delete();
  endtask

  function automatic mb_t act_bundle();
    return {bus.ex_opcode, bus.ex_dataA, bus.ex_dataB, bus.ex_offset, bus.ex_dest,
            bus.ex_wen, bus.ex_pc};
  endfunction

  vec_t vt[10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{32'h0008_0003, 3'd0, 3'd3, 1'b1, 32'h0000_0003};
    vt[1] = '{32'h0058_0004, 3'd1, 3'd4, 1'b1, 32'h0000_0004};
    vt[2] = '{32'h0082_0005, 3'd2, 3'd2, 1'b1, 32'h0000_0005};
    vt[3] = '{32'h0082_FFFF, 3'd2, 3'd2, 1'b1, 32'hFFFF_FFFF};
    vt[4] = '{32'h00CB_8010, 3'd3, 3'd0, 1'b0, 32'hFFFF_8010};
    vt[5] = '{32'h0111_8000, 3'd4, 3'd0, 1'b0, 32'hFFFF_8000};
    vt[6] = '{32'h0176_0000, 3'd5, 3'd6, 1'b1, 32'h0000_0000};
    vt[7] = '{32'h0180_0000, 3'd6, 3'd0, 1'b0, 32'h0000_0000};
    vt[8] = '{32'h01C0_7FFF, 3'd7, 3'd0, 1'b0, 32'h0000_7FFF};
    vt[9] = '{32'hFE3F_8007, 3'd0, 3'd7, 1'b1, 32'hFFFF_8007};

    do_reset();
    #1;
    chk("rst_ex_valid", bus.ex_valid, 0);
    chk("rst_halted", bus.halted, 0);
    chk("rst_bundle", act_bundle(), 0);

    foreach (vt[i]) begin
      do_reset();
      drv(1, vt[i].instr, 32'h100 + i, 1, 0, 0, 0);
      chk($sformatf("vec%0d_if_ready", i), bus.if_ready, 1);
      chk($sformatf("vec%0d_rf_addr", i), {bus.rf_regA, bus.rf_regB},
          {vt[i].instr[21:19], vt[i].instr[18:16]});
      tick();
      chk($sformatf("vec%0d_ex", i),
          {bus.ex_valid, bus.ex_opcode, bus.ex_dest, bus.ex_wen, bus.ex_offset, bus.ex_pc},
          {1'b1, vt[i].op, vt[i].dest, vt[i].wen, vt[i].off, 32'h100 + i});
      chk($sformatf("vec%0d_data", i), {bus.ex_dataA, bus.ex_dataB},
          {rfval(vt[i].instr[21:19]), rfval(vt[i].instr[18:16])});
    end

    // async reset mid-stream clears state without a clock edge
    do_reset();
    drv(1, 32'h0008_0003, 32'h10, 0, 0, 0, 0);
    tick();
    chk("t1_pre_valid", bus.ex_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("t1_async", {bus.ex_valid, bus.halted, bus.ex_dest}, 0);
    rst_n = 1'b1;
    drv(1, 32'h0058_0004, 32'h14, 1, 0, 0, 0);
    chk("t1_sb_cleared", bus.if_ready, 1);

    // RAW stall on r3 until its write-back retires
    do_reset();
    drv(1, 32'h0008_0003, 32'h20, 1, 0, 0, 0);
    chk("t2_add_rdy", bus.if_ready, 1);
    tick();
    drv(1, 32'h0058_0004, 32'h24, 1, 0, 0, 0);
    chk("t2_stall", bus.if_ready, 0);
    tick();
    chk("t2_drained", bus.ex_valid, 0);
    drv(1, 32'h0058_0004, 32'h24, 1, 1, 3, 0);
    chk("t2_no_bypass", bus.if_ready, 0);
    tick();
    drv(1, 32'h0058_0004, 32'h24, 1, 0, 0, 0);
    chk("t2_unstall", bus.if_ready, 1);
    tick();
    chk("t2_issue", {bus.ex_valid, bus.ex_opcode, bus.ex_dest, bus.ex_pc},
        {1'b1, 3'd1, 3'd4, 32'h24});

    // backpressure holds ID/EX
    do_reset();
    drv(1, 32'h000A_0005, 32'h30, 0, 0, 0, 0);
    tick();
    for (int k = 0; k < 3; k++) begin
      drv(1, 32'h01C0_0000, 32'h34, 0, 0, 0, 0);
      chk("t4_hold_rdy", bus.if_ready, 0);
      tick();
      chk("t4_hold", {bus.ex_valid, bus.ex_opcode, bus.ex_dest, bus.ex_wen, bus.ex_pc},
          {1'b1, 3'd0, 3'd5, 1'b1, 32'h30});
    end
    drv(1, 32'h01C0_0000, 32'h34, 1, 0, 0, 0);
    chk("t4_release_rdy", bus.if_ready, 1);
    tick();
    chk("t4_next", {bus.ex_valid, bus.ex_opcode, bus.ex_dest, bus.ex_wen, bus.ex_pc},
        {1'b1, 3'd7, 3'd0, 1'b0, 32'h34});

    // flush a writer to r4, then a reader of r4 needs no stall
    do_reset();
    drv(1, 32'h0000_0004, 32'h40, 0, 0, 0, 0);
    tick();
    drv(0, 0, 0, 0, 0, 0, 1);
    chk("t5_flush_blocks", bus.if_ready, 0);
    tick();
    chk("t5_killed", bus.ex_valid, 0);
    drv(1, 32'h0060_0001, 32'h44, 1, 0, 0, 0);
    chk("t5_reader_rdy", bus.if_ready, 1);
    tick();
    chk("t5_reader", {bus.ex_valid, bus.ex_opcode, bus.ex_pc}, {1'b1, 3'd1, 32'h44});

    // clear and set of r5 in one cycle leaves it pending
    do_reset();
    drv(1, 32'h000A_0005, 32'h50, 1, 1, 5, 0);
    chk("t6_rdy", bus.if_ready, 1);
    tick();
    drv(1, 32'h0068_0001, 32'h54, 1, 0, 0, 0);
    chk("t6_sb5_set", bus.if_ready, 0);

    // halt handshake
    do_reset();
    drv(1, 32'h0180_0000, 32'h60, 0, 0, 0, 0);
    tick();
    chk("t6_halt_issued", {bus.ex_valid, bus.ex_opcode, bus.halted}, {1'b1, 3'd6, 1'b0});
    drv(1, 32'h01C0_0000, 32'h64, 0, 0, 0, 0);
    chk("t6_halt_pend", bus.if_ready, 0);
    tick();
    drv(1, 32'h01C0_0000, 32'h64, 1, 0, 0, 0);
    chk("t6_halt_pend_rdy", bus.if_ready, 0);
    tick();
    chk("t6_halted", {bus.halted, bus.ex_valid}, {1'b1, 1'b0});
    for (int k = 0; k < 4; k++) begin
      drv(1, 32'h01C0_0000, 32'h68, 1, 0, 0, 0);
      chk("t6_stuck", {bus.if_ready, bus.halted}, {1'b0, 1'b1});
      tick();
    end
    rst_n = 1'b0;
    #1;
    chk("t6_rst_halted", bus.halted, 0);
    rst_n = 1'b1;

    // randomized stream against the model
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] ins, pc;
      logic [2:0]  op, wr;
      logic        iv, rdy, fl, wv, exp_rdy, issue, accept;
      dec_t        d;
      int          r;
      r   = $urandom_range(0, 99);
      op  = (r < 3) ? 3'd6 : 3'($urandom_range(0, 6));
      if (op == 3'd6 && r >= 3) op = 3'd7;
      ins = $urandom;
      ins[24:22] = op;
      pc  = $urandom;
      iv  = $urandom_range(0, 9) < 8;
      rdy = $urandom_range(0, 9) < 7;
      fl  = $urandom_range(0, 99) < 6;
      wv  = 0; wr = 0;
      if (xq.size() > 0 && $urandom_range(0, 1) == 1) begin
        wv = 1; wr = 3'(xq.pop_front());
      end else if ($urandom_range(0, 19) == 0) begin
        wv = 1; wr = 3'($urandom_range(0, 7));
      end
      drv(iv, ins, pc, rdy, wv, wr, fl);

      d = dec(ins);
      exp_rdy = (!m_exv || rdy) && !fl && !m_hp && !m_hlt &&
                !((d.ua && m_pend[ins[21:19]]) || (d.ub && m_pend[ins[18:16]]) ||
                  (d.wen && m_pend[d.dest]));
      chk("rnd_if_ready", bus.if_ready, exp_rdy);
      chk("rnd_rf_addr", {bus.rf_regA, bus.rf_regB}, {ins[21:19], ins[18:16]});
      issue  = iv && exp_rdy;
      accept = m_exv && rdy && !fl;

      if (accept) begin
        if (m_b.wen) xq.push_back(int'(m_b.dest));
        if (m_b.op == 3'd6) begin m_hlt = 1; m_hp = 0; end
      end
      if (wv) m_pend[wr] = 0;
      if (fl && m_exv) begin
        if (m_b.wen) m_pend[m_b.dest] = 0;
        if (m_b.op == 3'd6) m_hp = 0;
      end
      if (issue) begin
        if (d.wen) m_pend[d.dest] = 1;
        if (d.op == 3'd6) m_hp = 1;
      end
      if (fl) m_exv = 0;
      else if (issue) begin
        m_exv = 1;
        m_b = '{d.op, rfval(ins[21:19]), rfval(ins[18:16]), d.off, d.dest, d.wen, pc};
      end else if (accept) m_exv = 0;

      tick();
      chk("rnd_state", {bus.ex_valid, bus.halted}, {m_exv, m_hlt});
      chk("rnd_bundle", act_bundle(), m_b);
      if (m_hlt) begin
        do_reset();
        model_reset();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
